twiddle_gen: RTL and testbench

//  Parametrised FFT twiddle-factor generator, the successor to the fixed 0..90 deg sin/cos table.

---
 rtl/twiddle_pkg.sv | 31 +++
 rtl/twiddle_gen_if.sv | 32 +++
 rtl/twiddle_qrom.sv | 29 ++
 rtl/twiddle_gen.sv | 130 +++++++++++++
 tb/tb_twiddle_gen.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/twiddle_pkg.sv
// Shared definitions for the twiddle-factor generator.
//   twiddle_log2n(n)       : ceil(log2(n)) for elaboration-time sizing
//   qrom_val(i, n, w)      : round(S*cos(2*pi*i/n)), S = 2**(w-1)-1, half away from zero
//   twiddle_t              : {re, im} pair at the default word width
package twiddle_pkg;

  localparam int unsigned TwDefaultW = 16;
  localparam real         TwPi       = 3.14159265358979323846;

  typedef struct packed {
    logic signed [TwDefaultW-1:0] re;
    logic signed [TwDefaultW-1:0] im;
  } twiddle_t;

  function automatic int unsigned twiddle_log2n(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction

  function automatic int qrom_val(input int i, input int unsigned n, input int unsigned w);
    real s;
    real x;
    s = real'((2 ** (w - 1)) - 1);
    x = s * $cos(2.0 * TwPi * real'(i) / real'(n));
    if (x >= 0.0) return int'($floor(x + 0.5));
    else          return -int'($floor(-x + 0.5));
  endfunction

endpackage

// File: rtl/twiddle_gen_if.sv
// Request/response bus of the twiddle-factor generator.
//   in_valid/in_ready/in_k/in_inv   : index request channel
//   out_valid/out_ready/out_re/out_im : twiddle result channel
// master: requester side, slave: generator side.
interface twiddle_gen_if
  import twiddle_pkg::*;
#(
  parameter int unsigned N = 256,
  parameter int unsigned W = 16
);
  localparam int unsigned LOG2N = twiddle_log2n(N);

  logic                    in_valid;
  logic                    in_ready;
  logic [LOG2N-1:0]        in_k;
  logic                    in_inv;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [W-1:0]     out_re;
  logic signed [W-1:0]     out_im;

  modport master (
    output in_valid, in_k, in_inv, out_ready,
    input  in_ready, out_valid, out_re, out_im
  );

  modport slave (
    input  in_valid, in_k, in_inv, out_ready,
    output in_ready, out_valid, out_re, out_im
  );

endinterface

// File: rtl/twiddle_qrom.sv
// Quarter-wave cosine ROM, two read ports.
//   addr_a/addr_b : read addresses 0..N/4 (driven from the S1 registers)
//   data_a/data_b : round(S*cos(2*pi*addr/N)), unsigned W-1 bits
// Content is built at elaboration from qrom_val; the read addresses are registered
// upstream so the data path into S2 is a single registered-address read.
module twiddle_qrom
  import twiddle_pkg::*;
#(
  parameter int unsigned  N  = 256,
  parameter int unsigned  W  = 16,
  localparam int unsigned AW = twiddle_log2n(N) - 1
) (
  input  logic [AW-1:0] addr_a,
  input  logic [AW-1:0] addr_b,
  output logic [W-2:0]  data_a,
  output logic [W-2:0]  data_b
);
  localparam int unsigned Depth = N / 4 + 1;

  logic [W-2:0] rom [Depth];

  for (genvar i = 0; i < Depth; i++) begin : g_rom
    assign rom[i] = (W - 1)'(qrom_val(i, N, W));
  end

  assign data_a = rom[addr_a];
  assign data_b = rom[addr_b];

endmodule

// File: rtl/twiddle_gen.sv
// FFT twiddle-factor generator: k in [0,N) -> W_N^k = cos(2*pi*k/N) - j*sin(2*pi*k/N).
// Two-stage pipeline (S1: quadrant/addresses, S2: folded ROM data), valid/ready both sides.
//   clk   : clock, rising edge
//   rst_n : synchronous reset, active low
//   bus   : twiddle_gen_if slave (request k/inv in, re/im out)
// Optional feature: define TWIDDLE_INV_EN to honour in_inv (conjugate output); otherwise
// in_inv is ignored and the output is always the forward twiddle.
module twiddle_gen
  import twiddle_pkg::*;
#(
  parameter int unsigned N = 256,
  parameter int unsigned W = 16
) (
  input logic          clk,
  input logic          rst_n,
  twiddle_gen_if.slave bus
);
  localparam int unsigned LOG2N = twiddle_log2n(N);
  localparam int unsigned Q     = N / 4;
  localparam int unsigned AW    = LOG2N - 1;

  // Single global enable: every stage moves together unless the output is stalled.
  logic adv;

  logic          s1_valid_q;
  logic [1:0]    s1_quad_q;
  logic [AW-1:0] s1_addr_a_q;
  logic [AW-1:0] s1_addr_b_q;
  logic          s1_inv_q;

  logic [1:0]    quad_d;
  logic [AW-1:0] addr_a_d;
  logic [AW-1:0] addr_b_d;
  logic          inv_d;

  logic                out_valid_q;
  logic signed [W-1:0] out_re_q;
  logic signed [W-1:0] out_im_q;
  logic signed [W-1:0] re_d;
  logic signed [W-1:0] im_d;

  logic [W-2:0]        rom_a;
  logic [W-2:0]        rom_b;
  logic signed [W-1:0] t_a;
  logic signed [W-1:0] t_b;
  logic signed [W-1:0] c_val;
  logic signed [W-1:0] s_val;

  assign adv           = ~out_valid_q | bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = out_valid_q;
  assign bus.out_re    = out_re_q;
  assign bus.out_im    = out_im_q;

  // S1 next state: split k into quadrant and in-quadrant offset r; the two ROM
  // addresses are r and Q-r (the latter reaches Q, hence the extra address bit).
  always_comb begin
    quad_d   = bus.in_k[LOG2N-1 -: 2];
    addr_a_d = {1'b0, bus.in_k[LOG2N-3:0]};
    addr_b_d = AW'(Q) - addr_a_d;
  end

`ifdef TWIDDLE_INV_EN
  assign inv_d = bus.in_inv;
`else
  logic unused_inv;
  assign unused_inv = bus.in_inv;
  assign inv_d      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
    end else if (adv) begin
      s1_valid_q <= bus.in_valid;
    end
  end

  // Payload only loads on an accepted request; empty slots leave it untouched.
  always_ff @(posedge clk) begin
    if (adv && bus.in_valid) begin
      s1_quad_q   <= quad_d;
      s1_addr_a_q <= addr_a_d;
      s1_addr_b_q <= addr_b_d;
      s1_inv_q    <= inv_d;
    end
  end

  twiddle_qrom #(
    .N (N),
    .W (W)
  ) u_qrom (
    .addr_a (s1_addr_a_q),
    .addr_b (s1_addr_b_q),
    .data_a (rom_a),
    .data_b (rom_b)
  );

  assign t_a = signed'({1'b0, rom_a});
  assign t_b = signed'({1'b0, rom_b});

  // Quadrant fold; ROM values never exceed S so negation cannot overflow.
  always_comb begin
    c_val = t_a;
    s_val = t_b;
    unique case (s1_quad_q)
      2'd0: begin c_val =  t_a; s_val =  t_b; end
      2'd1: begin c_val = -t_b; s_val =  t_a; end
      2'd2: begin c_val = -t_a; s_val = -t_b; end
      2'd3: begin c_val =  t_b; s_val = -t_a; end
    endcase
    re_d = c_val;
    im_d = s1_inv_q ? s_val : -s_val;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
    end else if (adv) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_re_q <= re_d;
        out_im_q <= im_d;
      end
    end
  end

endmodule

// File: tb/tb_twiddle_gen.sv
// Self-checking bench for twiddle_gen (N=256, W=16): directed vector table, stall and
// reset sequences, plus sequential and random streams against a real-valued model.
module tb_twiddle_gen;
  import twiddle_pkg::*;

  localparam int unsigned N = 256;
  localparam int unsigned W = 16;
  localparam int          S = 32767;
  localparam real         Pi = 3.14159265358979323846;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  twiddle_gen_if #(.N(N), .W(W)) bus ();

  twiddle_gen #(
    .N (N),
    .W (W)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string    name;
    int       k;
    bit       inv;
    twiddle_t exp;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int got    = 0;

  bit [8:0] exp_q [$];  // {inv, k} of accepted requests, in order
  bit       stall_prev = 1'b0;
  int       prev_re;
  int       prev_im;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_near(input string name, input int act, input real exp);
    real d;
    checks++;
    d = real'(act) - exp;
    if (d > 1.0 || d < -1.0) begin
      errors++;
      $display("FAIL %s: got %0d, expected %f (+/-1)", name, act, exp);
    end
  endtask

  // Reference: W_N^k from the definition, conjugated for inverse requests when enabled.
  task automatic model(input int k, input bit inv, output real re, output real im);
    real a;
    a  = 2.0 * Pi * real'(k) / real'(N);
    re = real'(S) * $cos(a);
    im = -real'(S) * $sin(a);
`ifdef TWIDDLE_INV_EN
    if (inv) im = -im;
`endif
  endtask

  // One clock of bookkeeping with whatever the caller drives on the inputs.
  task automatic cycle(output bit acc);
    real    mre;
    real    mim;
    bit [8:0] e;
    #1;
    acc = bus.in_valid && bus.in_ready;
    if (stall_prev) begin
      chk("stall_out_valid", int'(bus.out_valid), 1);
      chk("stall_out_re", int'(bus.out_re), prev_re);
      chk("stall_out_im", int'(bus.out_im), prev_im);
    end
    if (bus.out_valid && !bus.out_ready) chk("stall_in_ready", int'(bus.in_ready), 0);
    if (acc) exp_q.push_back({bus.in_inv, bus.in_k});
    if (bus.out_valid && bus.out_ready) begin
      got++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got re=%0d im=%0d, expected no result",
                 bus.out_re, bus.out_im);
      end else begin
        e = exp_q.pop_front();
        model(int'(e[7:0]), e[8], mre, mim);
        chk_near($sformatf("stream_re k=%0d", e[7:0]), int'(bus.out_re), mre);
        chk_near($sformatf("stream_im k=%0d", e[7:0]), int'(bus.out_im), mim);
      end
    end
    stall_prev = bus.out_valid && !bus.out_ready;
    prev_re    = int'(bus.out_re);
    prev_im    = int'(bus.out_im);
    @(posedge clk);
    #1;
  endtask

  // Single request into an idle pipeline; checks the exact 2-cycle latency.
  task automatic send_one(input string name, input int k, input bit inv, input twiddle_t exp);
    bus.in_valid  = 1'b1;
    bus.in_k      = 8'(k);
    bus.in_inv    = inv;
    bus.out_ready = 1'b1;
    #1;
    chk({name, "_in_ready"}, int'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk({name, "_lat1_valid"}, int'(bus.out_valid), 0);
    @(posedge clk);
    #1;
    chk({name, "_lat2_valid"}, int'(bus.out_valid), 1);
    chk({name, "_re"}, int'(bus.out_re), int'(exp.re));
    chk({name, "_im"}, int'(bus.out_im), int'(exp.im));
    @(posedge clk);
    #1;
    chk({name, "_drained"}, int'(bus.out_valid), 0);
  endtask

  task automatic run_stream(input string name, input int cnt, input int rdy_pct, input bit rnd);
    int sent;
    int cyc;
    int first;
    int last;
    int k_cur;
    bit inv_cur;
    bit acc;
    sent = 0; cyc = 0; first = -1; last = -1; got = 0;
    exp_q.delete();
    stall_prev = 1'b0;
    k_cur   = rnd ? int'($urandom_range(0, N - 1)) : 0;
    inv_cur = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
    while (got < cnt && cyc < 5000) begin
      bus.in_valid  = (sent < cnt) && (!rnd || $urandom_range(0, 3) != 0);
      bus.in_k      = 8'(k_cur);
      bus.in_inv    = inv_cur;
      bus.out_ready = ($urandom_range(0, 99) < rdy_pct);
      if (bus.out_valid && bus.out_ready) begin
        if (first < 0) first = cyc;
        last = cyc;
      end
      cycle(acc);
      if (acc) begin
        sent++;
        k_cur   = rnd ? int'($urandom_range(0, N - 1)) : sent;
        inv_cur = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    chk({name, "_count"}, got, cnt);
    if (rdy_pct >= 100) chk({name, "_one_per_cycle"}, last - first, cnt - 1);
    repeat (3) cycle(acc);
    chk({name, "_no_extra"}, got, cnt);
    chk({name, "_queue_empty"}, exp_q.size(), 0);
  endtask

  vec_t vecs [9];

  initial begin : main
    bit acc;
    int kk;
    twiddle_t e;

    vecs[0] = '{"k0",   0,   1'b0, '{re:  16'sd32767, im:  16'sd0}};
    vecs[1] = '{"k64",  64,  1'b0, '{re:  16'sd0,     im: -16'sd32767}};
    vecs[2] = '{"k128", 128, 1'b0, '{re: -16'sd32767, im:  16'sd0}};
    vecs[3] = '{"k192", 192, 1'b0, '{re:  16'sd0,     im:  16'sd32767}};
    vecs[4] = '{"k32",  32,  1'b0, '{re:  16'sd23170, im: -16'sd23170}};
    vecs[5] = '{"k96",  96,  1'b0, '{re: -16'sd23170, im: -16'sd23170}};
    vecs[6] = '{"k224", 224, 1'b0, '{re:  16'sd23170, im:  16'sd23170}};
`ifdef TWIDDLE_INV_EN
    vecs[7] = '{"k64_inv", 64, 1'b1, '{re: 16'sd0,     im: 16'sd32767}};
    vecs[8] = '{"k32_inv", 32, 1'b1, '{re: 16'sd23170, im: 16'sd23170}};
`else
    vecs[7] = '{"k64_inv", 64, 1'b1, '{re: 16'sd0,     im: -16'sd32767}};
    vecs[8] = '{"k32_inv", 32, 1'b1, '{re: 16'sd23170, im: -16'sd23170}};
`endif

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_k      = '0;
    bus.in_inv    = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", int'(bus.out_valid), 0);
    chk("reset_out_re", int'(bus.out_re), 0);
    chk("reset_out_im", int'(bus.out_im), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset_in_ready", int'(bus.in_ready), 1);
    chk("post_reset_out_valid", int'(bus.out_valid), 0);

    foreach (vecs[i]) send_one(vecs[i].name, vecs[i].k, vecs[i].inv, vecs[i].exp);

    run_stream("seq_ready1", 256, 100, 1'b0);
    run_stream("seq_ready50", 256, 50, 1'b0);
    run_stream("rand", 200, 50, 1'b1);

    // Stall: fill the pipe with out_ready low, hold 5 cycles, then release.
    got = 0;
    exp_q.delete();
    stall_prev    = 1'b0;
    bus.out_ready = 1'b0;
    kk = 10;
    while (kk < 12) begin
      bus.in_valid = 1'b1;
      bus.in_k     = 8'(kk);
      cycle(acc);
      if (acc) kk++;
    end
    bus.in_k = 8'(kk);
    repeat (5) begin
      #1;
      chk("stall_hold_valid", int'(bus.out_valid), 1);
      chk("stall_hold_in_ready", int'(bus.in_ready), 0);
      cycle(acc);
      if (acc) kk++;
    end
    bus.out_ready = 1'b1;
    for (int c = 0; c < 20 && got < 3; c++) begin
      bus.in_valid = (kk <= 12);
      bus.in_k     = 8'(kk);
      cycle(acc);
      if (acc) kk++;
    end
    bus.in_valid = 1'b0;
    repeat (3) cycle(acc);
    chk("stall_result_count", got, 3);
    chk("stall_queue_empty", exp_q.size(), 0);

    // Reset with two results in flight.
    got = 0;
    exp_q.delete();
    stall_prev = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_k      = 8'd5;
    cycle(acc);
    bus.in_k      = 8'd6;
    cycle(acc);
    chk("flight_out_valid", int'(bus.out_valid), 1);
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("midreset_out_valid", int'(bus.out_valid), 0);
    chk("midreset_out_re", int'(bus.out_re), 0);
    chk("midreset_out_im", int'(bus.out_im), 0);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk("flushed_never_appear", int'(bus.out_valid), 0);
    end
    e = '{re: 16'sd0, im: -16'sd32767};
    send_one("after_reset_k64", 64, 1'b0, e);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
